div2_sequencer: RTL and testbench
=================================

// Module: div2_sequencer
// PURPOSE
//   Hardware sequencer for program-2 division: on Start, reads the 16-bit dividend and
//   8-bit divisor from data memory, runs a bit-serial restoring divide and writes the
//   24-bit quotient floor(dividend*256/divisor) back to data memory, then raises Ack.
//   Sits beside the data memory in CPU as a memory master (same Start/Ack contract as CPU).
// PARAMETERS
//   ADDR_W        8   data memory address width
//   DIVIDEND_ADDR 0   dividend MSB address (LSB at +1)
//   DIVISOR_ADDR  2   divisor address
//   RESULT_ADDR   4   result MSB address (bits 23:16), +1 = 15:8, +2 = 7:0
//   ROUND         0   0: truncate; 1: half-LSB upward rounding
// PORTS
//   Clk          in   1       clock, all state on rising edge
//   Reset        in   1       asynchronous, active-low reset
//   Start        in   1       launch request; rising edge sampled in IDLE or DONE
//   Ack          out  1       job complete; high in DONE until next launch
//   mem_addr     out  ADDR_W  data memory address (read and write)
//   mem_wr_en    out  1       write strobe, one cycle per byte
//   mem_wr_data  out  8       write data
//   mem_rd_data  in   8       read data, valid the cycle after mem_addr (sync read)
// BEHAVIOUR
//   - Reset low: state IDLE; Ack, mem_wr_en, mem_addr, mem_wr_data, all internal regs = 0.
//     Reset mid-job aborts immediately; no further writes; partial result never completes.
//   - Launch = Start high and registered Start low (rising edge), state IDLE or DONE.
//     Start edges while busy are ignored (not queued). Held-high Start launches once.
//   - FSM: IDLE -> RD0 (addr DIVIDEND) -> RD1 (addr +1, capture MSB) -> RD2 (addr DIVISOR,
//     capture LSB) -> RDW (capture divisor) -> DIV (NQ cycles) -> WR0 -> WR1 -> WR2 -> DONE.
//   - NQ = 24 (ROUND=0) or 25 (ROUND=1); one quotient bit per DIV cycle, MSB first.
//   - Divide: numerator N = dividend<<8 (ROUND=0) or dividend<<9 (ROUND=1); 9-bit partial
//     remainder; restoring shift-subtract; quotient register 25 bits.
//   - ROUND=1: result = q[24:1] + q[0]; never overflows 24 bits (max 0xFFFF00).
//   - Divisor == 0 (decided in RDW from mem_rd_data): skip DIV, result = 24'hFFFFFF.
//   - WR0/WR1/WR2: mem_wr_en=1, addr RESULT+0/+1/+2, data result[23:16]/[15:8]/[7:0].
//   - mem_wr_en = 0 in every other state; mem_addr = 0 in IDLE/DONE/DIV.
//   - Latency, launch edge = edge 0: Ack high after edge 7+NQ (31 trunc, 32 round);
//     zero divisor: after edge 7. Ack cleared on the launch edge of the next job.
//   - Dividend/divisor sampled only during RD states; later memory changes do not affect job.
// STRUCTURE
//   - Package div2_pkg: state enum (10 states), NQ_TRUNC=24, NQ_ROUND=25,
//     default address constants, DIV0_RESULT=24'hFFFFFF.
//   - Sub-module div2_iter: remainder/quotient/numerator shift registers + 9-bit
//     subtractor; inputs load, step, divisor; outputs quotient. FSM stays in div2_sequencer.
// TESTING
//   - 9 / 8, ROUND=0 -> mem[4..6] = 00 01 20; Ack exactly 31 cycles after launch edge.
//   - 2 / 3: ROUND=0 -> 00 00 AA; ROUND=1 -> 00 00 AB, Ack at 32. 1 / 3 ROUND=1 -> 00 00 55.
//   - 0xFFFF / 0x01 -> FF FF 00; 0x0003 / 0xFF -> 00 00 03 (both ROUND settings).
//   - 0x1234 / 0x00 -> FF FF FF, Ack after 7 cycles, no DIV cycles, exactly 3 writes.
//   - Reset low during DIV cycle 10 -> all outputs 0 at once, mem[4..6] unchanged;
//     release, Start edge -> correct result.
//   - Start held high across DONE -> single job; Start re-pulsed in DONE -> Ack drops, 2nd job.
//   - Scoreboard: random dividend/divisor vs floor(d*256/v) model; count writes = 3 per job.

Source files
------------

// File: rtl/div2_pkg.sv
// Shared types and constants for the program-2 division sequencer.
// Holds the FSM state encoding, quotient lengths and default memory map.
package div2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_RDW,
    ST_DIV,
    ST_WR0,
    ST_WR1,
    ST_WR2,
    ST_DONE
  } state_t;

  localparam int NQ_TRUNC = 24;
  localparam int NQ_ROUND = 25;
  localparam int QW       = 25;

  localparam int DEF_DIVIDEND_ADDR = 0;
  localparam int DEF_DIVISOR_ADDR  = 2;
  localparam int DEF_RESULT_ADDR   = 4;

  localparam logic [23:0] DIV0_RESULT = 24'hFFFFFF;

  // The rounded quotient carries one extra fraction bit; adding it back gives half-up rounding.
  function automatic logic [23:0] final_result(input logic [QW-1:0] q, input logic round);
    if (round) return q[24:1] + 24'(q[0]);
    else       return q[23:0];
  endfunction

endpackage

// File: rtl/div2_iter.sv
// Bit-serial restoring divider datapath: one quotient bit per step, MSB first.
// The numerator is always loaded as dividend<<9; truncating mode simply stops one step early.
module div2_iter
  import div2_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic          load,
  input  logic          step,
  input  logic [15:0]   dividend,
  input  logic [7:0]    divisor,
  output logic [QW-1:0] quotient
);

  logic [7:0]    rem;
  logic [QW-1:0] numer;
  logic [8:0]    rem_shift;
  logic          fits;

  assign rem_shift = {rem, numer[QW-1]};
  assign fits      = rem_shift >= {1'b0, divisor};

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rem      <= '0;
      numer    <= '0;
      quotient <= '0;
    end else if (load) begin
      rem      <= '0;
      numer    <= {dividend, 9'b0};
      quotient <= '0;
    end else if (step) begin
      // Remainder stays below the divisor, so its 9-bit working value always fits back in 8 bits.
      rem      <= fits ? 8'(rem_shift - {1'b0, divisor}) : rem_shift[7:0];
      numer    <= {numer[QW-2:0], 1'b0};
      quotient <= {quotient[QW-2:0], fits};
    end
  end

endmodule

// File: rtl/div2_sequencer.sv
// Memory-master sequencer: reads dividend/divisor, divides, writes the 24-bit quotient, raises Ack.
// Launches on a rising edge of Start while in IDLE or DONE.
module div2_sequencer
  import div2_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int DIVIDEND_ADDR = DEF_DIVIDEND_ADDR,
  parameter int DIVISOR_ADDR  = DEF_DIVISOR_ADDR,
  parameter int RESULT_ADDR   = DEF_RESULT_ADDR,
  parameter int ROUND         = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  input  logic [7:0]        mem_rd_data
);

  localparam int         NQ       = (ROUND != 0) ? NQ_ROUND : NQ_TRUNC;
  localparam logic [4:0] LAST_BIT = 5'(NQ - 1);

  state_t        state, state_nxt;
  logic          start_q;
  logic [15:0]   dividend;
  logic [7:0]    divisor;
  logic          div_zero;
  logic [4:0]    bit_cnt;
  logic          launch;
  logic [QW-1:0] quotient;
  logic [23:0]   result;

  assign launch = Start && !start_q && (state == ST_IDLE || state == ST_DONE);
  assign result = div_zero ? DIV0_RESULT : final_result(quotient, ROUND != 0);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      start_q  <= 1'b0;
      dividend <= '0;
      divisor  <= '0;
      div_zero <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      start_q <= Start;
      case (state)
        ST_RD1: dividend[15:8] <= mem_rd_data;
        ST_RD2: dividend[7:0]  <= mem_rd_data;
        ST_RDW: begin
          divisor  <= mem_rd_data;
          div_zero <= (mem_rd_data == 8'd0);
          bit_cnt  <= '0;
        end
        ST_DIV:  bit_cnt <= bit_cnt + 5'd1;
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    Ack         = 1'b0;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state)
      ST_IDLE: if (launch) state_nxt = ST_RD0;
      ST_RD0: begin
        mem_addr  = ADDR_W'(DIVIDEND_ADDR);
        state_nxt = ST_RD1;
      end
      ST_RD1: begin
        mem_addr  = ADDR_W'(DIVIDEND_ADDR + 1);
        state_nxt = ST_RD2;
      end
      ST_RD2: begin
        mem_addr  = ADDR_W'(DIVISOR_ADDR);
        state_nxt = ST_RDW;
      end
      ST_RDW:  state_nxt = (mem_rd_data == 8'd0) ? ST_WR0 : ST_DIV;
      ST_DIV:  if (bit_cnt == LAST_BIT) state_nxt = ST_WR0;
      ST_WR0: begin
        mem_wr_en   = 1'b1;
        mem_addr    = ADDR_W'(RESULT_ADDR);
        mem_wr_data = result[23:16];
        state_nxt   = ST_WR1;
      end
      ST_WR1: begin
        mem_wr_en   = 1'b1;
        mem_addr    = ADDR_W'(RESULT_ADDR + 1);
        mem_wr_data = result[15:8];
        state_nxt   = ST_WR2;
      end
      ST_WR2: begin
        mem_wr_en   = 1'b1;
        mem_addr    = ADDR_W'(RESULT_ADDR + 2);
        mem_wr_data = result[7:0];
        state_nxt   = ST_DONE;
      end
      ST_DONE: begin
        Ack = 1'b1;
        if (launch) state_nxt = ST_RD0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  div2_iter u_iter (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (state == ST_RDW),
    .step     (state == ST_DIV),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient)
  );

endmodule

// File: tb/tb_div2_sequencer.sv
// Bench for div2_sequencer: one truncating and one rounding instance, each with its own memory.
// Results are checked against plain-arithmetic floor/round division.
module tb_div2_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start   [2];
  logic       ack     [2];
  logic [7:0] addr    [2];
  logic       wr_en   [2];
  logic [7:0] wr_data [2];
  logic [7:0] rd_data [2];

  logic [7:0] mem [2][256];
  int         wr_cnt [2] = '{0, 0};

  logic       ld_en = 1'b0;
  logic       ld_sel = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  div2_sequencer #(.ROUND(0)) u_trunc (
    .Clk(Clk), .Reset(Reset), .Start(start[0]), .Ack(ack[0]),
    .mem_addr(addr[0]), .mem_wr_en(wr_en[0]), .mem_wr_data(wr_data[0]),
    .mem_rd_data(rd_data[0])
  );

  div2_sequencer #(.ROUND(1)) u_round (
    .Clk(Clk), .Reset(Reset), .Start(start[1]), .Ack(ack[1]),
    .mem_addr(addr[1]), .mem_wr_en(wr_en[1]), .mem_wr_data(wr_data[1]),
    .mem_rd_data(rd_data[1])
  );

  // Synchronous-read memories; the bench loads them through a separate port.
  always @(posedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      rd_data[i] <= mem[i][addr[i]];
      if (wr_en[i]) begin
        mem[i][addr[i]] <= wr_data[i];
        wr_cnt[i]       <= wr_cnt[i] + 1;
      end
    end
    if (ld_en) mem[ld_sel][ld_addr] <= ld_data;
  end

  function automatic logic [23:0] model(input int unsigned dvd, input int unsigned dvs,
                                        input int rnd);
    if (dvs == 0) return 24'hFFFFFF;
    if (rnd == 0) return 24'((dvd * 256) / dvs);
    return 24'((dvd * 512 + dvs) / (2 * dvs));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int i, input logic [7:0] a, input logic [7:0] d);
    @(negedge Clk);
    ld_en = 1'b1; ld_sel = i[0]; ld_addr = a; ld_data = d;
    @(negedge Clk);
    ld_en = 1'b0;
  endtask

  task automatic launch_and_wait(input int i, output int lat);
    @(negedge Clk);
    start[i] = 1'b1;
    @(posedge Clk);
    #1;
    check("ack_low_after_launch", ack[i], 0);
    lat = 0;
    while (ack[i] !== 1'b1 && lat < 200) begin
      @(posedge Clk);
      lat++;
      #1;
    end
  endtask

  task automatic run_job(input int i, input logic [15:0] dvd, input logic [7:0] dvs,
                         input bit hold, input string tag);
    int          base, lat, exp_lat;
    logic [23:0] got;
    poke(i, 8'd0, dvd[15:8]);
    poke(i, 8'd1, dvd[7:0]);
    poke(i, 8'd2, dvs);
    base = wr_cnt[i];
    launch_and_wait(i, lat);
    if (!hold) begin
      @(negedge Clk);
      start[i] = 1'b0;
    end
    exp_lat = (dvs == 0) ? 7 : 7 + 24 + i;
    got     = {mem[i][4], mem[i][5], mem[i][6]};
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, got, model(dvd, dvs, i));
    check({tag, "_writes"}, wr_cnt[i] - base, 3);
  endtask

  initial begin
    int          base;
    logic [15:0] rdvd;
    logic [7:0]  rdvs;

    Reset    = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_ack", ack[i], 0);
      check("reset_wr_en", wr_en[i], 0);
      check("reset_addr", addr[i], 0);
      check("reset_wr_data", wr_data[i], 0);
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b1;

    run_job(0, 16'h0009, 8'h08, 1'b0, "trunc_9_8");
    check("trunc_9_8_bytes", {mem[0][4], mem[0][5], mem[0][6]}, 24'h000120);
    run_job(0, 16'h0002, 8'h03, 1'b0, "trunc_2_3");
    run_job(0, 16'hFFFF, 8'h01, 1'b0, "trunc_ffff_1");
    run_job(0, 16'h0003, 8'hFF, 1'b0, "trunc_3_ff");
    run_job(0, 16'h1234, 8'h00, 1'b0, "trunc_div0");
    run_job(1, 16'h0002, 8'h03, 1'b0, "round_2_3");
    check("round_2_3_bytes", {mem[1][4], mem[1][5], mem[1][6]}, 24'h0000AB);
    run_job(1, 16'h0001, 8'h03, 1'b0, "round_1_3");
    run_job(1, 16'hFFFF, 8'h01, 1'b0, "round_ffff_1");
    run_job(1, 16'h0003, 8'hFF, 1'b0, "round_3_ff");
    run_job(1, 16'h1234, 8'h00, 1'b0, "round_div0");

    // Start held across DONE must not relaunch; a fresh pulse must.
    run_job(1, 16'h0100, 8'h07, 1'b1, "hold_first");
    base = wr_cnt[1];
    repeat (10) @(posedge Clk);
    #1;
    check("hold_ack_stays", ack[1], 1);
    check("hold_no_extra_writes", wr_cnt[1] - base, 0);
    @(negedge Clk);
    start[1] = 1'b0;
    run_job(1, 16'h7777, 8'h09, 1'b0, "hold_second");

    // Abort during DIV cycle 10: outputs clear at once, result bytes stay untouched.
    poke(0, 8'd4, 8'h5A);
    poke(0, 8'd5, 8'h5A);
    poke(0, 8'd6, 8'h5A);
    poke(0, 8'd0, 8'h43);
    poke(0, 8'd1, 8'h21);
    poke(0, 8'd2, 8'h37);
    base = wr_cnt[0];
    @(negedge Clk);
    start[0] = 1'b1;
    @(posedge Clk);
    repeat (13) @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("abort_ack", ack[i], 0);
      check("abort_wr_en", wr_en[i], 0);
      check("abort_addr", addr[i], 0);
      check("abort_wr_data", wr_data[i], 0);
    end
    @(negedge Clk);
    start[0] = 1'b0;
    repeat (40) @(posedge Clk);
    #1;
    check("abort_mem_kept", {mem[0][4], mem[0][5], mem[0][6]}, 24'h5A5A5A);
    check("abort_no_writes", wr_cnt[0] - base, 0);
    @(negedge Clk);
    Reset = 1'b1;
    run_job(0, 16'h4321, 8'h37, 1'b0, "after_abort");

    for (int k = 0; k < 24; k++) begin
      rdvd = 16'($urandom);
      rdvs = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_job(k % 2, rdvd, rdvs, 1'b0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
